// File: rtl/mem_responder.sv
// Responder for the byte-serial memory bus: byte RAM plus an IO window holding
// a TX byte FIFO, an RX holding register and the program-finished flag.
module mem_responder #(
    parameter int unsigned RAM_AW   = 17,
    parameter int unsigned TX_DEPTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_addr,
    input  logic [7:0]  mem_write,
    input  logic        r_nw_in,
    output logic [7:0]  mem_read,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        program_finished,
    output logic        tx_overflow
);

    localparam int unsigned PTR_W    = $clog2(TX_DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned RAM_SIZE = 1 << RAM_AW;
    localparam logic [2:0]  IO_UART  = 3'h0;
    localparam logic [2:0]  IO_HALT  = 3'h4;

    logic [7:0]        ram [RAM_SIZE];
    logic [7:0]        tx_mem [TX_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  tx_count;
    logic [CNT_W-1:0]  tx_count_nxt;
    logic [7:0]        rx_hold;
    logic              rx_full;

    logic [RAM_AW-1:0] ram_idx;
    logic [2:0]        io_sel;
    logic              is_io;
    logic              bus_rd;
    logic              bus_wr;
    logic              ram_we;
    logic              tx_push_req;
    logic              tx_push;
    logic              tx_pop;
    logic              tx_full;
    logic              tx_drop;
    logic              halt_wr;
    logic              rx_pop;
    logic              rx_cap;
    logic [7:0]        rd_data_nxt;
    logic              unused_addr;

    // Address decode and per-cycle bus strobes; rdy_in gates every bus-side effect
    assign ram_idx     = mem_addr[RAM_AW-1:0];
    assign io_sel      = mem_addr[2:0];
    assign is_io       = (mem_addr[17:16] == 2'b11);
    assign unused_addr = ^mem_addr[31:18];
    assign bus_rd      = rdy_in && r_nw_in;
    assign bus_wr      = rdy_in && !r_nw_in;
    assign ram_we      = bus_wr && !is_io && (ram_idx != '0);
    assign tx_push_req = bus_wr && is_io && (io_sel == IO_UART);
    assign halt_wr     = bus_wr && is_io && (io_sel == IO_HALT);
    assign rx_pop      = bus_rd && is_io && (io_sel == IO_UART) && rx_full;
    assign rx_cap      = rx_valid && !rx_full;

    // TX FIFO handshake; a pop frees the slot a same-cycle push lands in
    assign tx_valid     = (tx_count != '0);
    assign tx_data      = tx_mem[rd_ptr];
    assign tx_pop       = tx_valid && tx_ready;
    assign tx_full      = (tx_count == CNT_W'(TX_DEPTH));
    assign tx_push      = tx_push_req && (!tx_full || tx_pop);
    assign tx_drop      = tx_push_req && tx_full && !tx_pop;
    assign tx_count_nxt = tx_count + CNT_W'(tx_push) - CNT_W'(tx_pop);
    assign rx_ready     = !rx_full;

    // Read mux; address 0 is write-protected so it always reads back as zero
    always_comb begin
        rd_data_nxt = 8'h00;
        if (r_nw_in) begin
            if (is_io) begin
                if ((io_sel == IO_UART) && rx_full) begin
                    rd_data_nxt = rx_hold;
                end
            end else if (ram_idx != '0) begin
                rd_data_nxt = ram[ram_idx];
            end
        end
    end

    // Storage arrays carry no reset
    always_ff @(posedge clk_in) begin
        if (ram_we) begin
            ram[ram_idx] <= mem_write;
        end
        if (tx_push) begin
            tx_mem[wr_ptr] <= mem_write;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            mem_read         <= 8'h00;
            io_buffer_full   <= 1'b0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            tx_count         <= '0;
            tx_overflow      <= 1'b0;
            program_finished <= 1'b0;
            rx_hold          <= 8'h00;
            rx_full          <= 1'b0;
        end else begin
            if (rdy_in) begin
                mem_read <= rd_data_nxt;
            end
            if (tx_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (tx_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            tx_count <= tx_count_nxt;
            // Two-slot margin covers the controller's one-cycle-late sampling
            io_buffer_full <= (tx_count_nxt >= CNT_W'(TX_DEPTH - 2));
            if (tx_drop) begin
                tx_overflow <= 1'b1;
            end
            if (halt_wr) begin
                program_finished <= 1'b1;
            end
            if (rx_cap) begin
                rx_hold <= rx_data;
                rx_full <= 1'b1;
            end else if (rx_pop) begin
                rx_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: expected read bytes and TX bytes are queued
// by the stimulus and popped by monitors whenever the DUT presents them.
module tb_mem_responder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] mem_addr;
    logic [7:0]  mem_write;
    logic        r_nw_in;
    logic [7:0]  mem_read;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        program_finished;
    logic        tx_overflow;

    logic        rd_mark;
    logic        rd_pend;
    logic [7:0]  exp_rd[$];
    logic [7:0]  exp_tx[$];
    int          n_checks = 0;
    int          n_errors = 0;

    mem_responder #(.RAM_AW(17), .TX_DEPTH(8)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .rdy_in           (rdy_in),
        .mem_addr         (mem_addr),
        .mem_write        (mem_write),
        .r_nw_in          (r_nw_in),
        .mem_read         (mem_read),
        .io_buffer_full   (io_buffer_full),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .rx_ready         (rx_ready),
        .program_finished (program_finished),
        .tx_overflow      (tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // A checked bus cycle produces a mem_read value one edge later
    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) rd_pend <= 1'b0;
        else         rd_pend <= rd_mark && rdy_in;
    end

    always @(negedge clk_in) begin
        if (rd_pend) begin
            if (exp_rd.size() == 0) check("mem_read_unexpected", 32'(mem_read), 32'hFFFF_FFFF);
            else                    check("mem_read", 32'(mem_read), 32'(exp_rd.pop_front()));
        end
        if (rst_in && tx_valid && tx_ready) begin
            if (exp_tx.size() == 0) check("tx_data_unexpected", 32'(tx_data), 32'hFFFF_FFFF);
            else                    check("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
        end
    end

    // One bus cycle: drive just after an edge, sampled by the DUT on the next edge
    task automatic bus(input logic [31:0] a, input logic [7:0] d, input logic rnw,
                       input logic rdy, input logic chk, input logic [7:0] e);
        @(posedge clk_in);
        #1;
        mem_addr  = a;
        mem_write = d;
        r_nw_in   = rnw;
        rdy_in    = rdy;
        rd_mark   = chk;
        if (chk && rdy) exp_rd.push_back(e);
    endtask

    task automatic idle();
        bus(32'h0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        bus(a, d, 1'b0, 1'b1, 1'b1, 8'h00);
    endtask

    task automatic rd(input logic [31:0] a, input logic [7:0] e);
        bus(a, 8'h00, 1'b1, 1'b1, 1'b1, e);
    endtask

    task automatic txw(input logic [7:0] d, input logic keep);
        wr(32'h0003_0000, d);
        if (keep) exp_tx.push_back(d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; mem_addr = 32'h0; mem_write = 8'h00; r_nw_in = 1'b0;
        tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; rd_mark = 1'b0;
        #12;
        check("rst_mem_read", 32'(mem_read), 32'h0);
        check("rst_io_buffer_full", 32'(io_buffer_full), 32'h0);
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_rx_ready", 32'(rx_ready), 32'h1);
        check("rst_program_finished", 32'(program_finished), 32'h0);
        check("rst_tx_overflow", 32'(tx_overflow), 32'h0);
        rst_in = 1'b1;

        // RAM write/read and write-protected address 0
        wr(32'h0000_1234, 8'hA5);
        rd(32'h0000_1234, 8'hA5);
        wr(32'h0000_0000, 8'h77);
        rd(32'h0000_0000, 8'h00);

        // Streaming reads
        wr(32'h100, 8'h11); wr(32'h101, 8'h22); wr(32'h102, 8'h33); wr(32'h103, 8'h44);
        rd(32'h100, 8'h11); rd(32'h101, 8'h22); rd(32'h102, 8'h33); rd(32'h103, 8'h44);
        idle();

        // TX fill to the io_buffer_full threshold, then drain in order
        for (int i = 0; i < 5; i++) txw(8'h61 + 8'(i), 1'b1);
        idle();
        check("ibf_at_5", 32'(io_buffer_full), 32'h0);
        txw(8'h66, 1'b1);
        idle();
        check("ibf_at_6", 32'(io_buffer_full), 32'h1);
        check("tx_valid_filled", 32'(tx_valid), 32'h1);
        check("tx_head_a", 32'(tx_data), 32'h61);
        tx_ready = 1'b1;
        @(posedge clk_in); #1;
        check("ibf_after_pop", 32'(io_buffer_full), 32'h0);
        repeat (6) @(posedge clk_in);
        #1;
        check("tx_drained_a", 32'(tx_valid), 32'h0);
        check("exp_tx_empty_a", 32'(exp_tx.size()), 32'h0);
        tx_ready = 1'b0;

        // Full FIFO with simultaneous push and pop is accepted
        for (int i = 0; i < 8; i++) txw(8'h41 + 8'(i), 1'b1);
        idle();
        check("ibf_full", 32'(io_buffer_full), 32'h1);
        txw(8'h50, 1'b1);
        tx_ready = 1'b1;
        idle();
        check("no_overflow_pushpop", 32'(tx_overflow), 32'h0);
        repeat (10) @(posedge clk_in);
        #1;
        check("tx_drained_b", 32'(tx_valid), 32'h0);
        check("exp_tx_empty_b", 32'(exp_tx.size()), 32'h0);
        tx_ready = 1'b0;

        // Ninth push with no pop is dropped
        for (int i = 0; i < 9; i++) txw(8'h71 + 8'(i), i < 8);
        idle();
        check("overflow_set", 32'(tx_overflow), 32'h1);
        check("tx_head_overflow", 32'(tx_data), 32'h71);
        tx_ready = 1'b1;
        repeat (10) @(posedge clk_in);
        #1;
        check("tx_drained_c", 32'(tx_valid), 32'h0);
        check("exp_tx_empty_c", 32'(exp_tx.size()), 32'h0);
        check("overflow_sticky", 32'(tx_overflow), 32'h1);
        tx_ready = 1'b0;

        // RX holding register and halt flag
        @(posedge clk_in); #1;
        rx_data = 8'h5A; rx_valid = 1'b1;
        @(posedge clk_in); #1;
        rx_valid = 1'b0; rx_data = 8'h66;
        check("rx_ready_full", 32'(rx_ready), 32'h0);
        rd(32'h0003_0000, 8'h5A);
        idle();
        check("rx_ready_empty", 32'(rx_ready), 32'h1);
        rd(32'h0003_0000, 8'h00);
        wr(32'h0003_0004, 8'h01);
        idle();
        check("pf_set", 32'(program_finished), 32'h1);
        repeat (3) idle();
        check("pf_sticky", 32'(program_finished), 32'h1);
        rd(32'h0003_0004, 8'h00);

        // rdy_in low freezes bus-side state
        wr(32'h200, 8'h12);
        rd(32'h200, 8'h12);
        bus(32'h200, 8'h99, 1'b0, 1'b0, 1'b0, 8'h00);
        bus(32'h0003_0000, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h00);
        bus(32'h0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        check("rdy_mem_read_held", 32'(mem_read), 32'h12);
        check("rdy_no_push", 32'(tx_valid), 32'h0);
        rd(32'h200, 8'h12);
        idle();

        // Reset mid-drain
        for (int i = 0; i < 7; i++) txw(8'h30 + 8'(i), 1'b1);
        idle();
        tx_ready = 1'b1;
        @(posedge clk_in); #1;
        check("ibf_before_reset", 32'(io_buffer_full), 32'h1);
        rst_in = 1'b0;
        #1;
        check("reset_tx_valid", 32'(tx_valid), 32'h0);
        check("reset_ibf", 32'(io_buffer_full), 32'h0);
        check("reset_overflow", 32'(tx_overflow), 32'h0);
        check("reset_pf", 32'(program_finished), 32'h0);
        exp_tx.delete();
        tx_ready = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        rd(32'h0000_1234, 8'hA5);
        rd(32'h200, 8'h12);
        rd(32'h103, 8'h44);
        idle();
        idle();
        check("exp_rd_empty", 32'(exp_rd.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
